// File: rtl/alu_pkg.sv
// alu_pkg: op codes, multicycle classification and FSM state encoding for alu_multicycle
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRA  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  function automatic logic is_multicycle(input logic [3:0] op);
    return op == OP_MULU || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             busy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d;
  logic [WIDTH:0] sum, rem_sh, diff;
  // hi holds the running product top / remainder; lo holds multiplier / dividend being shifted out
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff = rem_sh - {1'b0, m_q};
    nxt_hi = div_q ? (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    nxt_lo = div_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    done = busy && cnt_q == '0;
    hi_d = start ? '0 : busy ? nxt_hi : hi_q;
    lo_d = start ? (is_div ? a : b) : busy ? nxt_lo : lo_q;
    m_d = start ? (is_div ? b : a) : m_q;
    div_d = start ? is_div : div_q;
    cnt_d = start ? CW'(WIDTH - 1) : (busy && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU with iterative MULU/DIVU and valid/ready handshake
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);
  logic [0:0] state_q, state_d;
  logic out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [WIDTH-1:0] sum, diff, alu_lo, it_lo, it_hi;
  logic accept, start, single, done, alu_ovf;
  assign in_ready = state_q == ST_IDLE;
  assign accept = in_valid && in_ready;
  assign start = accept && is_multicycle(op);
  assign single = accept && !is_multicycle(op);
  always_comb begin
    sum = data_a + data_b;
    diff = data_a - data_b;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_lo = data_a & data_b;
      OP_OR:   alu_lo = data_a | data_b;
      OP_XOR:  alu_lo = data_a ^ data_b;
      OP_ADD: begin
        alu_lo = sum;
        alu_ovf = data_a[WIDTH-1] == data_b[WIDTH-1] && sum[WIDTH-1] != data_a[WIDTH-1];
      end
      OP_SUB: begin
        alu_lo = diff;
        alu_ovf = data_a[WIDTH-1] != data_b[WIDTH-1] && diff[WIDTH-1] != data_a[WIDTH-1];
      end
      OP_SLL:  alu_lo = data_b << shamt;
      OP_SRL:  alu_lo = data_b >> shamt;
      OP_SRA:  alu_lo = $signed(data_b) >>> shamt;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, data_a < data_b};
      default: alu_lo = '0;
    endcase
  end
  always_comb begin
    state_d = start ? ST_RUN : done ? ST_IDLE : state_q;
    out_valid_d = single || done;
    res_lo_d = done ? it_lo : single ? alu_lo : res_lo_q;
    res_hi_d = done ? it_hi : single ? '0 : res_hi_q;
    ovf_d = done ? 1'b0 : single ? alu_ovf : ovf_q;
    zero_d = out_valid_d ? res_lo_d == '0 : zero_q;
  end
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (op == OP_DIVU),
    .busy   (state_q == ST_RUN),
    .a      (data_a),
    .b      (data_b),
    .done   (done),
    .nxt_lo (it_lo),
    .nxt_hi (it_hi)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign zero = zero_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed stimulus with a queued scoreboard checked when out_valid pulses
module tb_alu_multicycle;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SRA = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SLT = 4'b0111;
  localparam logic [3:0] SLTU = 4'b1000, XOR_ = 4'b1011, MULU = 4'b1100, DIVU = 4'b1101;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    int          at;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, zero, overflow;
  logic [3:0] op = 4'b0;
  logic [31:0] data_a = '0, data_b = '0, result_lo, result_hi;
  logic [4:0] shamt = '0;
  int cyc = 0, ncmp = 0, nfail = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_a(data_a), .data_b(data_b), .shamt(shamt), .out_valid(out_valid),
    .result_lo(result_lo), .result_hi(result_hi), .zero(zero), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("op%0h_lo", e.op), 64'(result_lo), 64'(e.lo));
        check($sformatf("op%0h_hi", e.op), 64'(result_hi), 64'(e.hi));
        check($sformatf("op%0h_zero", e.op), 64'(zero), 64'(e.z));
        check($sformatf("op%0h_ovf", e.op), 64'(overflow), 64'(e.ov));
        check($sformatf("op%0h_cycle", e.op), 64'(cyc), 64'(e.at));
      end
    end
  end
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s, input logic [31:0] elo, input logic [31:0] ehi,
                      input logic eov, output int acc);
    exp_t e;
    int guard = 0;
    in_valid = 1'b1;
    op = o;
    data_a = a;
    data_b = b;
    shamt = s;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    acc = cyc + 1;
    e.op = o;
    e.lo = elo;
    e.hi = ehi;
    e.z = elo == 32'd0;
    e.ov = eov;
    e.at = acc + ((o == MULU || o == DIVU) ? 32 : 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_lo"}, 64'(result_lo), 64'd0);
    check({tag, "_hi"}, 64'(result_hi), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd1);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, acc2, guard;
    logic [63:0] prod;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    send(ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 32'h0, 1'b1, acc);
    send(SUB, 32'd5, 32'd5, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    send(SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h1, 32'h0, 1'b0, acc);
    send(SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    send(SRA, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 32'h0, 1'b0, acc);
    send(XOR_, 32'h0000F0F0, 32'h00000FF0, 5'd0, 32'h0000FF00, 32'h0, 1'b0, acc);
    send(OR_, 32'h0000F0F0, 32'h00000FF0, 5'd0, 32'h0000FFF0, 32'h0, 1'b0, acc);
    send(SLL, 32'h0, 32'h1, 5'd31, 32'h80000000, 32'h0, 1'b0, acc);
    send(SRL, 32'h0, 32'h80000000, 5'd31, 32'h1, 32'h0, 1'b0, acc);
    send(SUB, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 32'h0, 1'b1, acc);
    send(ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    send(4'b1001, 32'd5, 32'd6, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    send(SLT, 32'd3, 32'hFFFFFFFE, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    send(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 32'hFFFFFFFE, 1'b0, acc);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("mulu_busy_%0d", i), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("mulu_ready_again", 64'(in_ready), 64'd1);
    send(DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, acc);
    send(DIVU, 32'h1234, 32'd0, 5'd0, 32'hFFFFFFFF, 32'h1234, 1'b0, acc);
    prod = 64'h12345678 * 64'h9ABCDEF0;
    send(MULU, 32'h12345678, 32'h9ABCDEF0, 5'd0, prod[31:0], prod[63:32], 1'b0, acc);
    send(DIVU, 32'hDEADBEEF, 32'h00012345, 5'd0, 32'hDEADBEEF / 32'h00012345,
         32'hDEADBEEF % 32'h00012345, 1'b0, acc);
    send(MULU, 32'd3, 32'd5, 5'd0, 32'd15, 32'd0, 1'b0, acc);
    send(ADD, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, acc2);
    check("held_add_accept_edge", 64'(acc2), 64'(acc + 33));
    send(DIVU, 32'd1000, 32'd3, 5'd0, 32'd333, 32'd1, 1'b0, acc);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    send(AND_, 32'h0000F0F0, 32'h00000FF0, 5'd0, 32'h000000F0, 32'h0, 1'b0, acc);
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised execute-stage ALU for the 5-stage pipeline. It extends the single-cycle ALU op set with XOR, SLL, SRA and SLTU, plus iterative unsigned multiply and divide. The block registers every result and uses a valid/ready handshake. The hazard unit stalls ID/EX on `in_ready` low while a multiply or divide iterates.

## Interface
- `WIDTH`, 32: datapath width; must be a power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width; derived, do not override.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept; an op is accepted on an edge where `in_valid && in_ready`.
- `op` in 4: operation code (`alu_pkg`).
- `data_a` in WIDTH: operand A / dividend / multiplicand.
- `data_b` in WIDTH: operand B / divisor / multiplier / shift source.
- `shamt` in SHW: shift amount.
- `out_valid` out 1: one-cycle pulse; result fields are valid this cycle.
- `result_lo` out WIDTH: result; low product half; quotient.
- `result_hi` out WIDTH: high product half; remainder; 0 for all other ops.
- `zero` out 1: `result_lo == 0`, qualified by `out_valid`.
- `overflow` out 1: signed overflow on ADD/SUB; 0 for all other ops.

## Operation
- Op codes, legacy-compatible: AND 0000, OR 0001, ADD 0010, SRA 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, XOR 1011, MULU 1100, DIVU 1101. All other codes are undefined.
- Shifts operate on `data_b` by `shamt`. SRA sign-extends.
- SLT is a signed compare and SLTU an unsigned compare; both give `{WIDTH-1 zeros, lt}`.
- ADD/SUB wrap modulo 2^WIDTH. `overflow` = operand signs agree (after B inversion for SUB) and the result sign differs.
- MULU: unsigned shift-add, one multiplier bit per cycle. Output is `{result_hi, result_lo}` = `data_a * data_b`, 2·WIDTH bits.
- DIVU: unsigned restoring division, one quotient bit per cycle. `result_lo` = quotient, `result_hi` = remainder.
- Divide by zero: quotient is all-ones, remainder is `data_a`. No trap, same latency.
- Undefined op: single-cycle; `result_lo`/`result_hi` = 0, `zero` = 1, `overflow` = 0.
- FSM states:
  - IDLE: `in_ready` = 1.
  - IDLE → RUN on accepting MULU/DIVU; operands latch, iteration counter loads WIDTH-1.
  - RUN: counter decrements each cycle; on the cycle it reaches 0, next state is IDLE and `out_valid` pulses on the following cycle.
  - Single-cycle ops stay in IDLE.
- Operand inputs are ignored while in RUN; `in_valid` asserted in RUN is not accepted.

## Timing
- Reset (`rst_n` low at an edge): state IDLE, counter 0, `out_valid` 0, `result_lo`/`result_hi` 0, `overflow` 0, `zero` 1. `in_ready` is 1 in the cycle after reset deasserts.
- Reset mid-RUN aborts the operation. No `out_valid` is produced for it.
- Single-cycle op accepted at edge k: `out_valid` = 1 in cycle k+1. Throughput is one op per cycle back-to-back.
- MULU/DIVU accepted at edge k:
  - `in_ready` = 0 for cycles k+1 … k+WIDTH.
  - `out_valid` = 1 in cycle k+WIDTH+1.
  - `in_ready` = 1 again in cycle k+WIDTH+1, so a new op can be accepted at the same edge the result is presented.
- No output backpressure: the consumer must take the result in its `out_valid` cycle. Outputs hold their last value otherwise.
- `zero` and `overflow` are registered together with `result_lo`.

## Structure
- `alu_pkg`: 4-bit op-code localparams, an `is_multicycle(op)` function, and FSM state encoding (IDLE, RUN).
- Sub-module `alu_muldiv_iter`: shared accumulator and shift register for MULU/DIVU. It has `start`/`done` ports and is parametrised by WIDTH.
- Single-cycle datapath and handshake FSM live in the top module.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 → next cycle `out_valid` = 1, `result_lo` = 0x80000000, `overflow` = 1, `zero` = 0.
- Back-to-back SUB 5−5, SLT 0xFFFFFFFF vs 1, SLTU same operands, SRA 0x80000000 by 4 → four consecutive `out_valid` pulses with:
  - `result_lo` = 0 with `zero` = 1;
  - 1;
  - 0;
  - 0xF8000000.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → `in_ready` low 32 cycles; `out_valid` at accept+33 with `result_hi` = 0xFFFFFFFE, `result_lo` = 0x00000001.
- DIVU 100 / 7 → quotient 14, remainder 2 at accept+33. DIVU 0x1234 / 0 → quotient 0xFFFFFFFF, remainder 0x1234.
- `in_valid` held high with an ADD during a MULU RUN → ADD not accepted until `in_ready` rises; its result arrives exactly one cycle after the MULU result.
- `rst_n` low at accept+10 of a DIVU → no `out_valid` for it, all outputs at reset values, `in_ready` = 1 the cycle after reset releases; a following AND 0xF0F0 & 0x0FF0 returns 0x00F0.
